pcpi_nibble_sequencer: RTL and testbench
========================================

PCPI_NIBBLE_SEQUENCER -- requirements
Module: pcpi_nibble_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: max WAIT cycles without pcpi_ready/pcpi_wait before abort (only with PCPI_TIMEOUT_EN).
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 Port clk  in  1  rising-edge clock for all state.
REQ-004 Port rst  in  1  asynchronous active-high reset.
REQ-005 Port nib_in  in  4  instruction nibble, sampled when nib_strobe=1.
REQ-006 Port nib_strobe  in  1  one nibble accepted per high cycle, LS nibble first.
REQ-007 Port pcpi_valid  out  1  instruction offered to coprocessor.
REQ-008 Port pcpi_insn  out  32  assembled instruction word.
REQ-009 Port pcpi_ready  in  1  coprocessor completed.
REQ-010 Port pcpi_wr  in  1  coprocessor returns a result with ready.
REQ-011 Port pcpi_wait  in  1  coprocessor claims instruction, still busy.
REQ-012 Port pcpi_rd  in  32  coprocessor result, valid with pcpi_ready.
REQ-013 Port res_nib  out  4  result nibble, LS first.
REQ-014 Port res_valid  out  1  res_nib valid.
REQ-015 Port res_ack  in  1  consumer takes res_nib this cycle.
REQ-016 Port busy  out  1  high in any state but IDLE.
REQ-017 Port done  out  1  one-cycle pulse when a transaction ends (any path).
REQ-018 Port err  out  1  timeout flag.

Function
REQ-019 States SHALL be IDLE, LOAD, WAIT, DRAIN; all outputs registered.
REQ-020 IDLE: strobe writes nib_in to pcpi_insn[3:0], cnt=1, goes LOAD; no strobe stays IDLE.
REQ-021 LOAD: strobe writes pcpi_insn[4*cnt+:4], cnt+1; no-strobe cycles hold state and cnt; no timeout in LOAD.
REQ-022 Strobe on 8th nibble (cnt=7) at cycle N SHALL give pcpi_valid=1 and state WAIT at N+1, cnt=0.
REQ-023 WAIT: pcpi_valid and pcpi_insn SHALL hold stable until pcpi_ready sampled high.
REQ-024 pcpi_ready at cycle M SHALL give pcpi_valid=0 at M+1; with pcpi_wr=1 capture pcpi_rd, enter DRAIN, res_valid=1, res_nib=rd[3:0] at M+1.
REQ-025 pcpi_ready with pcpi_wr=0 SHALL return IDLE at M+1 with done=1, no DRAIN.
REQ-026 DRAIN: res_ack with res_valid advances to next nibble next cycle; 8th ack SHALL give res_valid=0, done=1, IDLE next cycle.
REQ-027 res_ack while res_valid=0 SHALL be ignored; res_nib held stable until acked.
REQ-028 nib_strobe in WAIT/DRAIN SHALL be ignored (nibble dropped, no state change).
REQ-029 Same-cycle strobe and ready in WAIT: ready wins, strobe dropped.
REQ-030 err SHALL clear on first nibble strobe in IDLE.

Reset
REQ-031 rst SHALL immediately force IDLE, cnt=0, pcpi_valid=0, pcpi_insn=0, res_valid=0, res_nib=0, busy=0, done=0, err=0, timeout counter=0.
REQ-032 rst mid-LOAD/WAIT/DRAIN SHALL abandon the transaction; no done pulse.

Configuration
REQ-033 Macro PCPI_TIMEOUT_EN defined: WAIT counts cycles with pcpi_ready=0 and pcpi_wait=0; pcpi_wait=1 clears count; count reaching TIMEOUT_CYCLES SHALL drop pcpi_valid, set err=1 (sticky), pulse done, return IDLE next cycle.
REQ-034 Macro undefined: no counter logic; WAIT waits indefinitely; err tied 0.

Structure
REQ-035 Shared package pcpi_seq_pkg SHALL hold state enum, NIBBLES=8, NIB_W=4, XLEN=32.
REQ-036 Timeout counter SHALL be sub-module pcpi_timeout_ctr (clear, enable, expire), instantiated only under PCPI_TIMEOUT_EN.

Verification
REQ-037 Strobe nibbles 3,2,1,0,B,A,9,8 consecutively -> pcpi_insn=0x89AB0123, pcpi_valid high cycle after 8th strobe.
REQ-038 Ready+wr with rd=0xDEADBEEF, res_ack held 1 -> res_nib F,E,E,B,D,A,E,D over 8 cycles, then done pulse, busy=0.
REQ-039 Ready with wr=0 -> pcpi_valid low next cycle, done pulse, res_valid never high.
REQ-040 Gapped strobes (idle cycles between) and strobes during WAIT -> pcpi_insn unaffected by WAIT strobes.
REQ-041 PCPI_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ready/wait -> err=1, pcpi_valid=0, IDLE after 4 WAIT cycles; pcpi_wait pulses reset count.
REQ-042 rst asserted mid-DRAIN (after 3 acks) -> all outputs reset values immediately, no done pulse.

Source files
------------

// File: rtl/pcpi_seq_pkg.sv
// Shared types and sizes for the PCPI nibble sequencer.
package pcpi_seq_pkg;

   localparam int NIBBLES = 8;
   localparam int NIB_W   = 4;
   localparam int XLEN    = 32;
   localparam int CNT_W   = $clog2(NIBBLES);

   localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DRAIN = 2'd3
   } seq_state_e;

   function automatic logic [NIB_W-1:0] nib_sel(input logic [XLEN-1:0] word,
                                                input logic [CNT_W-1:0] idx);
      return word[{idx, 2'b00} +: NIB_W];
   endfunction

endpackage

// File: rtl/pcpi_timeout_ctr.sv
// WAIT-phase watchdog: counts enabled cycles, expires on the LIMIT-th one.
module pcpi_timeout_ctr #(
   parameter int LIMIT = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int W = $clog2(LIMIT + 1) + 1;

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + W'(1'b1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Combinational so the FSM aborts on the cycle after the LIMIT-th idle WAIT cycle.
   assign expire_o = en_i && (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/pcpi_nibble_sequencer.sv
// Serial nibble front-end for a PCPI coprocessor: assembles an instruction, waits, drains the result.
// Optional WAIT watchdog enabled by defining PCPI_TIMEOUT_EN.
module pcpi_nibble_sequencer
   import pcpi_seq_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NIB_W-1:0] nib_in,
   input  logic             nib_strobe,
   output logic             pcpi_valid,
   output logic [XLEN-1:0]  pcpi_insn,
   input  logic             pcpi_ready,
   input  logic             pcpi_wr,
   input  logic             pcpi_wait,
   input  logic [XLEN-1:0]  pcpi_rd,
   output logic [NIB_W-1:0] res_nib,
   output logic             res_valid,
   input  logic             res_ack,
   output logic             busy,
   output logic             done,
   output logic             err
);

   seq_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0]  insn_q, insn_d;
   logic [XLEN-1:0]  rd_q, rd_d;
   logic [NIB_W-1:0] res_nib_q, res_nib_d;
   logic             valid_q, valid_d;
   logic             res_valid_q, res_valid_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             busy_q;
   logic             to_expire_s;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

`ifdef PCPI_TIMEOUT_EN
   logic to_clear_s;
   logic to_en_s;

   assign to_clear_s = (state_q != ST_WAIT) || pcpi_wait;
   assign to_en_s    = (state_q == ST_WAIT) && !pcpi_ready && !pcpi_wait;

   pcpi_timeout_ctr #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i    (clk),
      .rst_i    (rst),
      .clear_i  (to_clear_s),
      .en_i     (to_en_s),
      .expire_o (to_expire_s)
   );
`else
   logic unused_wait_s;

   assign unused_wait_s = pcpi_wait;
   assign to_expire_s   = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      insn_d      = insn_q;
      rd_d        = rd_q;
      res_nib_d   = res_nib_q;
      valid_d     = valid_q;
      res_valid_d = res_valid_q;
      done_d      = 1'b0;
      err_d       = err_q;
      case (state_q)
         ST_IDLE: begin
            if (nib_strobe) begin
               insn_d[NIB_W-1:0] = nib_in;
               cnt_d             = CNT_W'(1);
               err_d             = 1'b0;
               state_d           = ST_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (nib_strobe) begin
               insn_d[{cnt_q, 2'b00} +: NIB_W] = nib_in;
               if (cnt_q == LAST_NIB) begin
                  cnt_d   = '0;
                  valid_d = 1'b1;
                  state_d = ST_WAIT;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               state_d = ST_LOAD;
            end
         end
         // Ready outranks both a same-cycle strobe and the watchdog.
         ST_WAIT: begin
            if (pcpi_ready) begin
               valid_d = 1'b0;
               cnt_d   = '0;
               if (pcpi_wr) begin
                  rd_d        = pcpi_rd;
                  res_nib_d   = pcpi_rd[NIB_W-1:0];
                  res_valid_d = 1'b1;
                  state_d     = ST_DRAIN;
               end else begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end else if (to_expire_s) begin
               valid_d = 1'b0;
               err_d   = 1'b1;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_DRAIN: begin
            if (res_valid_q && res_ack) begin
               if (cnt_q == LAST_NIB) begin
                  cnt_d       = '0;
                  res_valid_d = 1'b0;
                  done_d      = 1'b1;
                  state_d     = ST_IDLE;
               end else begin
                  cnt_d     = cnt_q + CNT_W'(1);
                  res_nib_d = nib_sel(rd_q, cnt_q + CNT_W'(1));
               end
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         insn_q      <= '0;
         rd_q        <= '0;
         res_nib_q   <= '0;
         valid_q     <= 1'b0;
         res_valid_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         insn_q      <= insn_d;
         rd_q        <= rd_d;
         res_nib_q   <= res_nib_d;
         valid_q     <= valid_d;
         res_valid_q <= res_valid_d;
         done_q      <= done_d;
         err_q       <= err_d;
         busy_q      <= (state_d != ST_IDLE);
      end
   end

   assign pcpi_valid = valid_q;
   assign pcpi_insn  = insn_q;
   assign res_nib    = res_nib_q;
   assign res_valid  = res_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_pcpi_nibble_sequencer.sv
// Randomised self-checking bench for pcpi_nibble_sequencer against a word/nibble-level model.
module tb_pcpi_nibble_sequencer;

`ifdef PCPI_TIMEOUT_EN
   localparam int TO    = 4;
   localparam bit TO_EN = 1'b1;
`else
   localparam int TO    = 255;
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  nib_in = 4'h0;
   logic        nib_strobe = 1'b0;
   logic        pcpi_valid;
   logic [31:0] pcpi_insn;
   logic        pcpi_ready = 1'b0;
   logic        pcpi_wr = 1'b0;
   logic        pcpi_wait = 1'b0;
   logic [31:0] pcpi_rd = 32'h0;
   logic [3:0]  res_nib;
   logic        res_valid;
   logic        res_ack = 1'b0;
   logic        busy;
   logic        done;
   logic        err;

   int checks = 0;
   int errors = 0;

   pcpi_nibble_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .nib_in     (nib_in),
      .nib_strobe (nib_strobe),
      .pcpi_valid (pcpi_valid),
      .pcpi_insn  (pcpi_insn),
      .pcpi_ready (pcpi_ready),
      .pcpi_wr    (pcpi_wr),
      .pcpi_wait  (pcpi_wait),
      .pcpi_rd    (pcpi_rd),
      .res_nib    (res_nib),
      .res_valid  (res_valid),
      .res_ack    (res_ack),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] nib_of(input logic [31:0] w, input int i);
      return 4'((w >> (4 * i)) & 32'hF);
   endfunction

   // Strobes the 8 nibbles of w LS first, with up to max_gap idle cycles before each.
   task automatic load_word(input logic [31:0] w, input int max_gap);
      logic [2:0] exp3;
      int gap;
      for (int i = 0; i < 8; i++) begin
         gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         for (int g = 0; g < gap; g++) begin
            nib_strobe = 1'b0;
            nib_in = 4'($urandom);
            tick();
         end
         nib_strobe = 1'b1;
         nib_in = nib_of(w, i);
         tick();
         nib_strobe = 1'b0;
         exp3 = (i == 7) ? 3'b110 : 3'b010;
         checks++;
         if ({pcpi_valid, busy, done} !== exp3) begin
            errors++;
            $display("FAIL load_flags nib%0d: got %b expected %b", i, {pcpi_valid, busy, done}, exp3);
         end
      end
      checks++;
      if (pcpi_insn !== w) begin
         errors++;
         $display("FAIL load_insn: got %h expected %h", pcpi_insn, w);
      end
   endtask

   // Holds WAIT for n cycles with stray strobes/acks; pcpi_wait kept high so no watchdog counting.
   task automatic stall_wait(input logic [31:0] w, input int n);
      for (int c = 0; c < n; c++) begin
         pcpi_wait = 1'b1;
         nib_strobe = 1'($urandom);
         nib_in = 4'($urandom);
         res_ack = 1'($urandom);
         tick();
         checks++;
         if ({pcpi_valid, busy, done, res_valid} !== 4'b1100 || pcpi_insn !== w) begin
            errors++;
            $display("FAIL wait_hold: got flags %b insn %h expected 1100 insn %h",
                     {pcpi_valid, busy, done, res_valid}, pcpi_insn, w);
         end
      end
      pcpi_wait = 1'b0;
      nib_strobe = 1'b0;
      res_ack = 1'b0;
   endtask

   // Completes WAIT with ready; a same-cycle strobe is offered to check that it is dropped.
   task automatic complete(input logic wr, input logic [31:0] rd);
      logic [3:0] exp4;
      pcpi_ready = 1'b1;
      pcpi_wr = wr;
      pcpi_rd = rd;
      nib_strobe = 1'b1;
      nib_in = 4'($urandom);
      tick();
      pcpi_ready = 1'b0;
      pcpi_wr = 1'b0;
      pcpi_rd = 32'($urandom);
      nib_strobe = 1'b0;
      exp4 = wr ? 4'b0110 : 4'b0001;
      checks++;
      if ({pcpi_valid, res_valid, busy, done} !== exp4) begin
         errors++;
         $display("FAIL ready_flags: got %b expected %b", {pcpi_valid, res_valid, busy, done}, exp4);
      end
   endtask

   // Consumes the 8 result nibbles of rd with up to max_stall idle cycles before each ack.
   task automatic drain(input logic [31:0] rd, input int max_stall);
      int stall;
      for (int i = 0; i < 8; i++) begin
         stall = (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
         for (int s = 0; s < stall; s++) begin
            res_ack = 1'b0;
            nib_strobe = 1'($urandom);
            nib_in = 4'($urandom);
            tick();
            checks++;
            if (res_nib !== nib_of(rd, i) || {res_valid, busy, done} !== 3'b110) begin
               errors++;
               $display("FAIL drain_hold nib%0d: got %h/%b expected %h/110",
                        i, res_nib, {res_valid, busy, done}, nib_of(rd, i));
            end
         end
         checks++;
         if (res_nib !== nib_of(rd, i) || res_valid !== 1'b1) begin
            errors++;
            $display("FAIL drain_nib%0d: got %h valid %b expected %h valid 1",
                     i, res_nib, res_valid, nib_of(rd, i));
         end
         res_ack = 1'b1;
         nib_strobe = 1'b0;
         tick();
      end
      res_ack = 1'b0;
      checks++;
      if ({res_valid, busy, done} !== 3'b001) begin
         errors++;
         $display("FAIL drain_end: got %b expected 001", {res_valid, busy, done});
      end
      tick();
      checks++;
      if ({res_valid, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL done_pulse: got %b expected 000", {res_valid, busy, done});
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      #3;
      checks++;
      if ({pcpi_valid, res_valid, busy, done, err} !== 5'b0 || pcpi_insn !== 32'h0 || res_nib !== 4'h0) begin
         errors++;
         $display("FAIL reset_state: got flags %b insn %h nib %h expected all zero",
                  {pcpi_valid, res_valid, busy, done, err}, pcpi_insn, res_nib);
      end
      tick();
      tick();
      rst = 1'b0;
      res_ack = 1'b1;
      tick();
      tick();
      res_ack = 1'b0;
      checks++;
      if ({res_valid, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL idle_ack_ignored: got %b expected 000", {res_valid, busy, done});
      end
   endtask

   task automatic test_directed;
      load_word(32'h89AB0123, 0);
      stall_wait(32'h89AB0123, 4);
      complete(1'b1, 32'hDEADBEEF);
      drain(32'hDEADBEEF, 0);
   endtask

   task automatic test_no_write;
      logic [31:0] w;
      w = $urandom;
      load_word(w, 2);
      stall_wait(w, 2);
      complete(1'b0, 32'hFFFFFFFF);
      tick();
      checks++;
      if ({pcpi_valid, res_valid, busy, done} !== 4'b0000) begin
         errors++;
         $display("FAIL no_write_after: got %b expected 0000", {pcpi_valid, res_valid, busy, done});
      end
   endtask

   task automatic test_random;
      logic [31:0] w;
      logic [31:0] rd;
      logic        wr;
      for (int t = 0; t < 15; t++) begin
         w = $urandom;
         rd = $urandom;
         wr = 1'($urandom_range(3, 0) != 0);
         load_word(w, 3);
         stall_wait(w, $urandom_range(5, 0));
         complete(wr, rd);
         if (wr) begin
            drain(rd, 3);
         end else begin
            tick();
         end
      end
   endtask

   // Watchdog model: consecutive WAIT cycles without ready/wait; abort when the run reaches TO.
   task automatic test_timeout;
      logic [31:0] w;
      int run;
      bit aborted;
      logic [3:0] exp4;
      w = $urandom;
      load_word(w, 1);
      run = 0;
      aborted = 1'b0;
      for (int c = 0; c < 300 && !aborted; c++) begin
         pcpi_wait = (c == 2 || c == 5);
         tick();
         run = pcpi_wait ? 0 : run + 1;
         if (TO_EN && run >= TO) aborted = 1'b1;
         exp4 = aborted ? 4'b0011 : 4'b1100;
         checks++;
         if ({pcpi_valid, busy, done, err} !== exp4) begin
            errors++;
            $display("FAIL timeout_cycle%0d: got %b expected %b", c, {pcpi_valid, busy, done, err}, exp4);
         end
      end
      pcpi_wait = 1'b0;
      if (aborted) begin
         tick();
         checks++;
         if ({pcpi_valid, busy, done, err} !== 4'b0001) begin
            errors++;
            $display("FAIL err_sticky: got %b expected 0001", {pcpi_valid, busy, done, err});
         end
         w = $urandom;
         load_word(w, 0);
         checks++;
         if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got %b expected 0", err);
         end
      end
      complete(1'b0, 32'h0);
      tick();
   endtask

   task automatic test_reset_mid_drain;
      logic [31:0] w;
      logic [31:0] rd;
      w = $urandom;
      rd = $urandom;
      load_word(w, 0);
      complete(1'b1, rd);
      for (int i = 0; i < 3; i++) begin
         res_ack = 1'b1;
         tick();
      end
      res_ack = 1'b0;
      checks++;
      if (res_nib !== nib_of(rd, 3) || res_valid !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_nib: got %h expected %h", res_nib, nib_of(rd, 3));
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({pcpi_valid, res_valid, busy, done, err} !== 5'b0 || pcpi_insn !== 32'h0 || res_nib !== 4'h0) begin
         errors++;
         $display("FAIL async_reset: got flags %b insn %h nib %h expected all zero",
                  {pcpi_valid, res_valid, busy, done, err}, pcpi_insn, res_nib);
      end
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         res_ack = 1'b1;
         tick();
         checks++;
         if ({res_valid, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL post_reset%0d: got %b expected 000", i, {res_valid, busy, done});
         end
      end
      res_ack = 1'b0;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_no_write();
      test_random();
      test_timeout();
      test_reset_mid_drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
